// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial-pattern detector.
// Tracks the length of the matched PATTERN prefix, with KMP-style fallback on
// mismatch, and flags a hit combinationally on the final matching bit.
// A saturating counter records the number of hits.
module mealy_seq_detector #(
    parameter int           N       = 3,
    parameter logic [N-1:0] PATTERN = 3'b101,
    parameter bit           OVERLAP = 1'b0,
    parameter int           CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 x,
    input  logic                 clr,
    output logic                 y,
    output logic [$clog2(N)-1:0] state_o,
    output logic [CNT_W-1:0]     match_cnt
);

    localparam int SW = $clog2(N);

    // Elaboration-time transition: from prefix length k, append bit b and
    // return the longest j < N such that the last j bits equal the first j
    // PATTERN bits. j = N is the hit itself, so the result for the final bit
    // of a hit is the longest proper border of PATTERN.
    function automatic int kmp_next(input int k, input int b);
        int best;
        int idx;
        bit ok;
        bit sb;
        best = 0;
        for (int j = 1; j < N; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int t = 0; t < N; t++) begin
                    if (t < j) begin
                        idx = k + 1 - j + t;
                        sb  = (idx < k) ? PATTERN[N-1-idx] : b[0];
                        if (sb != PATTERN[N-1-t]) ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    logic [SW-1:0]    nxt0 [N];
    logic [SW-1:0]    nxt1 [N];
    logic [SW-1:0]    state_q, state_d;
    logic [SW-1:0]    fail_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    for (genvar k = 0; k < N; k++) begin : g_nxt
        localparam int NX0 = kmp_next(k, 0);
        localparam int NX1 = kmp_next(k, 1);
        assign nxt0[k] = SW'(NX0);
        assign nxt1[k] = SW'(NX1);
    end

    // Look up the transition for the current state; unreachable encodings go to 0.
    always_comb begin
        fail_nxt = '0;
        for (int k = 0; k < N; k++) begin
            if (state_q == SW'(k)) fail_nxt = x ? nxt1[k] : nxt0[k];
        end
    end

    // Mealy hit: last prefix bit matched and the incoming bit completes the pattern.
    always_comb begin
        hit = reset & en & (state_q == SW'(N - 1)) & (x == PATTERN[0]);
    end

    // Next state: hold when idle, restart after a hit in non-overlap mode.
    always_comb begin
        state_d = state_q;
        if (en) begin
            if (hit && !OVERLAP) state_d = '0;
            else                 state_d = fail_nxt;
        end
    end

    // Hit counter: clear wins over a simultaneous hit; saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)                      cnt_d = '0;
        else if (hit && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y         = hit;
    assign state_o   = state_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Testbench for mealy_seq_detector: four configurations driven by a shared
// stream, checked against constant vectors and a history-based reference model.
module tb_mealy_seq_detector;

    logic clk = 1'b0;
    logic reset, en, x, clr;
    always #5 clk = ~clk;

    logic       y0, y1, y2, y3;
    logic [1:0] s0, s1, s2, s3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;

    mealy_seq_detector #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) u0 (
        .clk(clk), .reset(reset), .en(en), .x(x), .clr(clr),
        .y(y0), .state_o(s0), .match_cnt(c0));
    mealy_seq_detector #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) u1 (
        .clk(clk), .reset(reset), .en(en), .x(x), .clr(clr),
        .y(y1), .state_o(s1), .match_cnt(c1));
    mealy_seq_detector #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u2 (
        .clk(clk), .reset(reset), .en(en), .x(x), .clr(clr),
        .y(y2), .state_o(s2), .match_cnt(c2));
    mealy_seq_detector #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) u3 (
        .clk(clk), .reset(reset), .en(en), .x(x), .clr(clr),
        .y(y3), .state_o(s3), .match_cnt(c3));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_y(input int i);
        case (i)
            0: return int'(y0);
            1: return int'(y1);
            2: return int'(y2);
            default: return int'(y3);
        endcase
    endfunction

    function automatic int dut_st(input int i);
        case (i)
            0: return int'(s0);
            1: return int'(s1);
            2: return int'(s2);
            default: return int'(s3);
        endcase
    endfunction

    function automatic int dut_cnt(input int i);
        case (i)
            0: return int'(c0);
            1: return int'(c1);
            2: return int'(c2);
            default: return int'(c3);
        endcase
    endfunction

    // Reference model: accepted-bit history (bit 0 newest) plus the number of
    // bits that may still contribute to a match since reset or a restart.
    int          m_n   [4] = '{3, 3, 4, 3};
    logic [15:0] m_pat [4] = '{16'h5, 16'h5, 16'hD, 16'h5};
    bit          m_ov  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int          m_max [4] = '{255, 255, 255, 3};
    logic [31:0] m_h   [4];
    int          m_len [4];
    int          m_cnt [4];
    int          obs_y [4];

    function automatic bit sfx_eq(input logic [31:0] h, input int j, input int n,
                                  input logic [15:0] pat);
        for (int i = 0; i < j; i++) begin
            if (h[i] != pat[n-j+i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit model_hit(input int i, input bit b);
        logic [31:0] h2;
        h2 = {m_h[i][30:0], b};
        return (m_len[i] + 1 >= m_n[i]) && sfx_eq(h2, m_n[i], m_n[i], m_pat[i]);
    endfunction

    function automatic int model_state(input int i);
        int st;
        st = 0;
        for (int j = 1; j < m_n[i]; j++) begin
            if (j <= m_len[i] && sfx_eq(m_h[i], j, m_n[i], m_pat[i])) st = j;
        end
        return st;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_h[i]   = '0;
            m_len[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic model_update(input int i, input bit e, input bit b, input bit c);
        bit h;
        h = e && model_hit(i, b);
        if (e) begin
            m_h[i]   = {m_h[i][30:0], b};
            m_len[i] = (m_len[i] < 32) ? m_len[i] + 1 : 32;
            if (h && !m_ov[i]) m_len[i] = 0;
        end
        if (c)                           m_cnt[i] = 0;
        else if (h && m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
    endtask

    // One clock of stimulus: y checked mid-cycle, state/count after the edge.
    task automatic step(input bit e, input bit b, input bit c);
        @(negedge clk);
        en = e; x = b; clr = c;
        #1;
        for (int i = 0; i < 4; i++) begin
            obs_y[i] = dut_y(i);
            check($sformatf("model y u%0d", i), obs_y[i], (e && model_hit(i, b)) ? 1 : 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            model_update(i, e, b, c);
            check($sformatf("model state u%0d", i), dut_st(i), model_state(i));
            check($sformatf("model cnt u%0d", i), dut_cnt(i), m_cnt[i]);
        end
    endtask

    // Reset pulse between clock edges, with x/en set to provoke a hit.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; en = 1'b1; x = 1'b1; clr = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset y u%0d", i), dut_y(i), 0);
            check($sformatf("reset state u%0d", i), dut_st(i), 0);
            check($sformatf("reset cnt u%0d", i), dut_cnt(i), 0);
        end
        #2;
        reset = 1'b1; en = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit rst; bit en; bit x; bit clr;
        int y0; int s0; int c0;
        int y1; int s1; int c1;
    } vec_t;

    vec_t        tbl [16];
    logic [6:0]  seq4;
    int          ey4 [7] = '{0, 0, 0, 1, 0, 0, 1};
    int          es4 [7] = '{1, 2, 3, 1, 2, 3, 1};
    logic [12:0] seq6;
    int          hits6;

    initial begin
        // 101 detectors: non-overlap (u0) and overlap (u1)
        tbl[0]  = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 2, 0, 0, 2, 0};
        tbl[2]  = '{0, 1, 1, 0, 1, 0, 1, 1, 1, 1};
        tbl[3]  = '{0, 1, 0, 0, 0, 0, 1, 0, 2, 1};
        tbl[4]  = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 2};
        // "11" must not fall back to 0
        tbl[5]  = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[6]  = '{0, 1, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[7]  = '{0, 1, 0, 0, 0, 2, 0, 0, 2, 0};
        tbl[8]  = '{0, 1, 1, 0, 1, 0, 1, 1, 1, 1};
        // en gap holds state at 2
        tbl[9]  = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[10] = '{0, 1, 0, 0, 0, 2, 0, 0, 2, 0};
        tbl[11] = '{0, 0, 1, 0, 0, 2, 0, 0, 2, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 2, 0, 0, 2, 0};
        tbl[13] = '{0, 0, 1, 0, 0, 2, 0, 0, 2, 0};
        tbl[14] = '{0, 1, 1, 0, 1, 0, 1, 1, 1, 1};
        // clr without hit clears count, leaves state
        tbl[15] = '{0, 1, 0, 1, 0, 0, 0, 0, 2, 0};

        reset = 1'b0; en = 1'b0; x = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int r = 0; r < 16; r++) begin
            if (tbl[r].rst) do_reset();
            step(tbl[r].en, tbl[r].x, tbl[r].clr);
            check($sformatf("tbl%0d y u0", r), obs_y[0], tbl[r].y0);
            check($sformatf("tbl%0d state u0", r), int'(s0), tbl[r].s0);
            check($sformatf("tbl%0d cnt u0", r), int'(c0), tbl[r].c0);
            check($sformatf("tbl%0d y u1", r), obs_y[1], tbl[r].y1);
            check($sformatf("tbl%0d state u1", r), int'(s1), tbl[r].s1);
            check($sformatf("tbl%0d cnt u1", r), int'(c1), tbl[r].c1);
        end

        // 1101 with overlap: border length 1
        do_reset();
        seq4 = 7'b1101101;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, seq4[6-i], 1'b0);
            check($sformatf("p1101 y bit%0d", i + 1), obs_y[2], ey4[i]);
            check($sformatf("p1101 state bit%0d", i + 1), int'(s2), es4[i]);
        end
        check("p1101 cnt", int'(c2), 2);

        // 2-bit counter saturation
        do_reset();
        seq6  = 13'b1010101010101;
        hits6 = 0;
        for (int i = 0; i < 13; i++) begin
            step(1'b1, seq6[12-i], 1'b0);
            hits6 += obs_y[3];
        end
        check("sat hits", hits6, 6);
        check("sat cnt", int'(c3), 3);

        // clr together with a hit
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("clr+hit y", obs_y[3], 1);
        check("clr+hit cnt", int'(c3), 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("post clr cnt", int'(c3), 1);
        step(1'b1, 1'b0, 1'b0);
        check("mid state", int'(s3), 2);

        // async reset mid-pattern, no clock edge in between
        en = 1'b1; x = 1'b1; reset = 1'b0;
        #1;
        check("async state", int'(s3), 0);
        check("async cnt", int'(c3), 0);
        check("async y", int'(y3), 0);
        check("async state u1", int'(s1), 0);
        model_reset();
        #1;
        reset = 1'b1; en = 1'b0;

        // randomized stream against the model
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(99) == 0) do_reset();
            else step(bit'($urandom_range(9) < 7), bit'($urandom_range(1)),
                      bit'($urandom_range(19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
